// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the 5-stage pipeline sequencer.
//   state_t : sequencer FSM states
//   ctl_t   : per-stage control vector
//             {pc_load, ifid_ld, ifid_flush, idex_ld, idex_flush,
//              exmem_ld, memwb_flush}
//   CTL_*   : canned control vectors for the common pipeline modes
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_load;
    logic ifid_ld;
    logic ifid_flush;
    logic idex_ld;
    logic idex_flush;
    logic exmem_ld;
    logic memwb_flush;
  } ctl_t;

  // Every stage advances, nothing is squashed.
  localparam ctl_t CTL_NORMAL = ctl_t'(7'b1101010);
  // Data memory busy: hold everything upstream, drain a bubble into WB.
  localparam ctl_t CTL_FREEZE = ctl_t'(7'b0000001);
  // Post-reset quiet period: nothing loads, every bubble point flushes.
  localparam ctl_t CTL_INIT   = ctl_t'(7'b0010101);
  // Hung memory: pipeline completely stopped.
  localparam ctl_t CTL_HALT   = ctl_t'(7'b0000000);

endpackage

// File: rtl/pipe_ctrl_lduse_det.sv
// -----------------------------------------------------------------------------
// lduse_det
// Combinational load-use hazard compare between the load in EX and the
// instruction in ID.
//   i_idex_mem_read : EX holds a load
//   i_idex_rt       : load destination register
//   i_ifid_rs/rt    : source register fields of the ID instruction
//   i_use_rs/rt     : ID instruction actually reads that field
//   o_lduse         : ID must stall one cycle
// -----------------------------------------------------------------------------
module lduse_det
  import pipe_ctrl_pkg::*;
(
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_use_rs,
  input  logic       i_use_rt,
  output logic       o_lduse
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_use_rs && (i_idex_rt == i_ifid_rs);
  assign w_rt_hit = i_use_rt && (i_idex_rt == i_ifid_rt);

  // $zero is hardwired, so a load "into" it never produces a real dependency.
  assign o_lduse = i_idex_mem_read && (i_idex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central sequencer for the 5-stage MIPS pipeline. Merges load-use stalls,
// branch/jump flushes and data-memory wait states into one priority-ordered
// set of per-stage load/flush controls, holds the pipe quiet after reset and
// traps a hung data memory into a sticky error state.
//
// Ports:
//   clk, rst               : clock (rising edge), async active-low reset
//   IDEX__* / IFID__*      : register fields and use flags for load-use check
//   ID__jump               : jump decoded in ID
//   EX__branch__taken      : branch resolved taken in EX
//   dmem__req/dmem__ready  : data memory access handshake
//   pc__load, *__Ld        : stage register enables
//   *__flush               : stage registers load a bubble
//   hazard                 : load-use stall active this cycle
//   mem__timeout           : high while in ERR
//   stall__cnt             : saturating count of stalled cycles
//   o_dbg_state            : current FSM state (pipe_ctrl_pkg::state_t encoding)
//
// Handshake: a data-memory access is pending while dmem__req=1; it completes
// in a cycle where dmem__ready=1. A cycle with dmem__req=1 and dmem__ready=0
// is a wait cycle and freezes the pipeline.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDEX__Rt,
  input  logic             IDEX__mem__read,
  input  logic [4:0]       IFID__Rs,
  input  logic [4:0]       IFID__Rt,
  input  logic             IFID__use__rs,
  input  logic             IFID__use__rt,
  input  logic             ID__jump,
  input  logic             EX__branch__taken,
  input  logic             dmem__req,
  input  logic             dmem__ready,
  output logic             pc__load,
  output logic             IFID__Ld,
  output logic             IFID__flush,
  output logic             IDEX__Ld,
  output logic             IDEX__flush,
  output logic             EXMEM__Ld,
  output logic             MEMWB__flush,
  output logic             hazard,
  output logic             mem__timeout,
  output logic [CNT_W-1:0] stall__cnt,
  output logic [1:0]       o_dbg_state
);

  localparam logic [3:0] INIT_LAST = 4'(RESET_HOLD - 1);
  localparam logic [8:0] WAIT_MAX  = 9'(MEM_TIMEOUT);

  state_t           r_state;
  logic [3:0]       r_init_cnt;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_lduse;
  logic       w_wait;
  logic       w_active;
  logic [8:0] w_wait_inc;
  ctl_t       w_ctl;
  logic       w_hazard;

  lduse_det u_lduse (
    .i_idex_mem_read (IDEX__mem__read),
    .i_idex_rt       (IDEX__Rt),
    .i_ifid_rs       (IFID__Rs),
    .i_ifid_rt       (IFID__Rt),
    .i_use_rs        (IFID__use__rs),
    .i_use_rt        (IFID__use__rt),
    .o_lduse         (w_lduse)
  );

  assign w_wait     = dmem__req && !dmem__ready;
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
  assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

  // Control decode. MEM_WAIT with the access completing (or withdrawn) is an
  // ordinary RUN cycle, so both states share the priority chain.
  always_comb begin
    w_ctl    = CTL_HALT;
    w_hazard = 1'b0;
    case (r_state)
      ST_INIT: w_ctl = CTL_INIT;
      ST_RUN, ST_MEM_WAIT: begin
        if (w_wait) begin
          w_ctl = CTL_FREEZE;
        end else if (EX__branch__taken) begin
          // ID holds a wrong-path instruction, so its hazards are moot.
          w_ctl            = CTL_NORMAL;
          w_ctl.ifid_flush = 1'b1;
          w_ctl.idex_flush = 1'b1;
        end else if (w_lduse) begin
          // Hold PC and IF/ID, inject a bubble into EX. A pending jump is
          // simply seen again next cycle.
          w_ctl            = CTL_NORMAL;
          w_ctl.pc_load    = 1'b0;
          w_ctl.ifid_ld    = 1'b0;
          w_ctl.idex_flush = 1'b1;
          w_hazard         = 1'b1;
        end else if (ID__jump) begin
          w_ctl            = CTL_NORMAL;
          w_ctl.ifid_flush = 1'b1;
        end else begin
          w_ctl = CTL_NORMAL;
        end
      end
      ST_ERR:  w_ctl = CTL_HALT;
      default: w_ctl = CTL_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 4'd0;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + 4'd1;
          end
        end
        ST_RUN, ST_MEM_WAIT: begin
          if (w_wait) begin
            r_wait_cnt <= w_wait_inc[7:0];
            r_state    <= (w_wait_inc >= WAIT_MAX) ? ST_ERR : ST_MEM_WAIT;
          end else begin
            r_wait_cnt <= 8'd0;
            r_state    <= ST_RUN;
          end
        end
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Stalled cycle = active cycle in which the PC did not advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_active && !w_ctl.pc_load && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pc__load     = w_ctl.pc_load;
  assign IFID__Ld     = w_ctl.ifid_ld;
  assign IFID__flush  = w_ctl.ifid_flush;
  assign IDEX__Ld     = w_ctl.idex_ld;
  assign IDEX__flush  = w_ctl.idex_flush;
  assign EXMEM__Ld    = w_ctl.exmem_ld;
  assign MEMWB__flush = w_ctl.memwb_flush;
  assign hazard       = w_hazard;
  assign mem__timeout = (r_state == ST_ERR);
  assign stall__cnt   = r_stall_cnt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl with RESET_HOLD=2, MEM_TIMEOUT=4, CNT_W=4
// (small counter so saturation is reachable). A behavioural model predicts
// {state, stall__cnt, pc__load, IFID__Ld, IFID__flush, IDEX__Ld, IDEX__flush,
//  EXMEM__Ld, MEMWB__flush, hazard, mem__timeout} for every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int HOLD = 2;
  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int W    = 2 + CW + 9;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MW   = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic          clk;
  logic          rst;
  logic [4:0]    IDEX__Rt;
  logic          IDEX__mem__read;
  logic [4:0]    IFID__Rs;
  logic [4:0]    IFID__Rt;
  logic          IFID__use__rs;
  logic          IFID__use__rt;
  logic          ID__jump;
  logic          EX__branch__taken;
  logic          dmem__req;
  logic          dmem__ready;
  logic          pc__load;
  logic          IFID__Ld;
  logic          IFID__flush;
  logic          IDEX__Ld;
  logic          IDEX__flush;
  logic          EXMEM__Ld;
  logic          MEMWB__flush;
  logic          hazard;
  logic          mem__timeout;
  logic [CW-1:0] stall__cnt;
  logic [1:0]    o_dbg_state;

  pipe_ctrl #(
    .RESET_HOLD  (HOLD),
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .IDEX__Rt          (IDEX__Rt),
    .IDEX__mem__read   (IDEX__mem__read),
    .IFID__Rs          (IFID__Rs),
    .IFID__Rt          (IFID__Rt),
    .IFID__use__rs     (IFID__use__rs),
    .IFID__use__rt     (IFID__use__rt),
    .ID__jump          (ID__jump),
    .EX__branch__taken (EX__branch__taken),
    .dmem__req         (dmem__req),
    .dmem__ready       (dmem__ready),
    .pc__load          (pc__load),
    .IFID__Ld          (IFID__Ld),
    .IFID__flush       (IFID__flush),
    .IDEX__Ld          (IDEX__Ld),
    .IDEX__flush       (IDEX__flush),
    .EXMEM__Ld         (EXMEM__Ld),
    .MEMWB__flush      (MEMWB__flush),
    .hazard            (hazard),
    .mem__timeout      (mem__timeout),
    .stall__cnt        (stall__cnt),
    .o_dbg_state       (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model + scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  int            n_pass;
  int            n_total;
  logic [1:0]    m_state;
  int            m_init;
  int            m_wait;
  logic [CW-1:0] m_stall;
  logic          m_pc;

  task automatic model_reset();
    m_state = S_INIT;
    m_init  = 0;
    m_wait  = 0;
    m_stall = '0;
  endtask

  // Predict this cycle's outputs from the model state and current inputs.
  task automatic predict();
    logic [8:0] e;
    logic       lu;
    logic       wc;
    lu = IDEX__mem__read && (IDEX__Rt != 5'd0) &&
         (((IDEX__Rt == IFID__Rs) && IFID__use__rs) ||
          ((IDEX__Rt == IFID__Rt) && IFID__use__rt));
    wc = dmem__req && !dmem__ready;
    //            pc ifl iff idl idf exl mwf haz to
    if (m_state == S_INIT)      e = 9'b0_0_1_0_1_0_1_0_0;
    else if (m_state == S_ERR)  e = 9'b0_0_0_0_0_0_0_0_1;
    else if (wc)                e = 9'b0_0_0_0_0_0_1_0_0;
    else if (EX__branch__taken) e = 9'b1_1_1_1_1_1_0_0_0;
    else if (lu)                e = 9'b0_0_0_1_1_1_0_1_0;
    else if (ID__jump)          e = 9'b1_1_1_1_0_1_0_0_0;
    else                        e = 9'b1_1_0_1_0_1_0_0_0;
    m_pc = e[8];
    exp_q.push_back({m_state, m_stall, e});
  endtask

  task automatic compare(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    obs = {o_dbg_state, stall__cnt, pc__load, IFID__Ld, IFID__flush, IDEX__Ld,
           IDEX__flush, EXMEM__Ld, MEMWB__flush, hazard, mem__timeout};
    exp_v = exp_q.pop_front();
    n_total = n_total + 1;
    assert (obs === exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h (state,stall,pc,ifl,iff,idl,idf,exl,mwf,haz,to)",
             tag, obs, exp_v);
    end
  endtask

  // Model the clock edge that ends the current cycle.
  task automatic model_edge();
    logic wc;
    wc = dmem__req && !dmem__ready;
    case (m_state)
      S_INIT: begin
        if (m_init == HOLD - 1) m_state = S_RUN;
        else m_init = m_init + 1;
      end
      S_RUN, S_MW: begin
        if (!m_pc && (m_stall != {CW{1'b1}})) m_stall = m_stall + 1'b1;
        if (wc) begin
          m_wait  = m_wait + 1;
          m_state = (m_wait >= TMO) ? S_ERR : S_MW;
        end else begin
          m_wait  = 0;
          m_state = S_RUN;
        end
      end
      default: m_state = S_ERR;
    endcase
  endtask

  // Called at posedge+1: drive-time prediction, check before the next edge.
  task automatic step(input string tag);
    predict();
    #3;
    compare(tag);
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic sample(input string tag);
    predict();
    #1;
    compare(tag);
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt,
                        input logic jmp, input logic br, input logic req, input logic rdy);
    IDEX__mem__read   = mr;
    IDEX__Rt          = xrt;
    IFID__Rs          = rs;
    IFID__Rt          = rt;
    IFID__use__rs     = urs;
    IFID__use__rt     = urt;
    ID__jump          = jmp;
    EX__branch__taken = br;
    dmem__req         = req;
    dmem__ready       = rdy;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    m_pc    = 1'b0;
    rst     = 1'b0;
    idle();
    model_reset();

    // Reset held across an edge.
    @(posedge clk);
    #1;
    sample("reset_hold");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // INIT quiet period, even with a memory request pending.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("init0");
    step("init1");
    idle();
    step("run0");

    // Load-use via Rs.
    set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs");
    idle();
    step("after_lu");
    // Register 0 never stalls.
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_r0");
    // Load-use via Rt.
    set_in(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rt");
    // Matching field not actually read.
    set_in(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_nouse");
    // Not a load.
    set_in(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_noload");
    // Branch beats load-use and jump.
    set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("br_lu");
    // Jump alone, then jump behind a load-use.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jump");
    set_in(1'b1, 5'd12, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jump_lu");
    set_in(1'b0, 5'd12, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jump_retry");

    // Three wait cycles; the last also carries a branch that must be ignored.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wait0");
    step("wait1");
    EX__branch__taken = 1'b1;
    step("wait2_br");
    EX__branch__taken = 1'b0;
    dmem__ready = 1'b1;
    step("wait_done");
    idle();
    step("back_run");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("req_rdy");

    // Held load-use long enough to saturate the stall counter.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("sat");
    idle();
    step("sat_done");

    // Async reset in the middle of MEM_WAIT.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mw0");
    step("mw1");
    #1;
    rst = 1'b0;
    model_reset();
    sample("async_rst_mw");
    @(posedge clk);
    #1;
    sample("rst_low_edge");
    rst = 1'b1;

    // Memory hang: INIT, then four wait cycles into ERR, ERR is sticky.
    step("init0_b");
    step("init1_b");
    for (int i = 0; i < TMO; i++) step("tmo_wait");
    step("err0");
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("err_inputs");
    idle();
    step("err_idle");

    // Reset is the only exit from ERR.
    #1;
    rst = 1'b0;
    model_reset();
    sample("async_rst_err");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS pipeline. It merges load-use stall detection, control-transfer flushes, and multi-cycle data-memory wait states into one priority-ordered set of per-stage load/flush controls. It holds the pipeline quiet for a fixed number of cycles after reset and traps a hung data memory into a sticky error state. It drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
RESET_HOLD, 2, cycles the pipeline is held in INIT after reset release; legal range 1..15
MEM_TIMEOUT, 16, consecutive data-memory wait cycles before ERR is entered; legal range 1..255
CNT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
IDEX__Rt  in  5  destination register of the instruction in EX
IDEX__mem__read  in  1  instruction in EX is a load
IFID__Rs  in  5  Rs field of the instruction in ID
IFID__Rt  in  5  Rt field of the instruction in ID
IFID__use__rs  in  1  instruction in ID reads Rs
IFID__use__rt  in  1  instruction in ID reads Rt
ID__jump  in  1  jump decoded in ID
EX__branch__taken  in  1  branch resolved taken in EX
dmem__req  in  1  load or store in MEM is accessing memory
dmem__ready  in  1  data memory completes the access this cycle
pc__load  out  1  PC register enable
IFID__Ld  out  1  IF/ID enable
IFID__flush  out  1  IF/ID loads a NOP
IDEX__Ld  out  1  ID/EX enable
IDEX__flush  out  1  ID/EX loads a bubble
EXMEM__Ld  out  1  EX/MEM enable
MEMWB__flush  out  1  MEM/WB loads a bubble
hazard  out  1  load-use stall is active this cycle (active-high)
mem__timeout  out  1  sticky; high while in ERR
stall__cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- FSM has states INIT, RUN, MEM_WAIT and ERR. State and counters are registered. All control outputs are combinational, from the state and the current inputs.
- Reset (rst=0, asynchronous): state=INIT, init_cnt=0, wait_cnt=0, stall__cnt=0. Outputs take their INIT values immediately, including when reset is asserted mid-operation.
- INIT outputs: all *__Ld=0, IFID__flush=IDEX__flush=MEMWB__flush=1, hazard=0, mem__timeout=0.
- INIT lasts exactly RESET_HOLD cycles after reset release, then moves to RUN.
- ERR: all *__Ld=0, all flushes=0, mem__timeout=1. Only reset leaves ERR.
- A wait cycle is a cycle in RUN or MEM_WAIT with dmem__req=1 and dmem__ready=0.
  - Every wait cycle freezes the pipeline: pc__load=IFID__Ld=IDEX__Ld=EXMEM__Ld=0, MEMWB__flush=1, IFID__flush=IDEX__flush=0, hazard=0.
  - A wait cycle overrides branch, jump and load-use handling.
  - RUN goes to MEM_WAIT after a wait cycle. wait_cnt counts consecutive wait cycles.
  - If wait_cnt reaches MEM_TIMEOUT at the end of a wait cycle, the next state is ERR.
  - In MEM_WAIT, a cycle with dmem__ready=1 or dmem__req=0 is a normal RUN cycle, evaluated by the priorities below. The next state is RUN and wait_cnt clears.
- Normal RUN cycle, highest priority first:
  1. EX__branch__taken=1: pc__load=1, IFID__flush=1, IDEX__flush=1, all other Ld=1, hazard=0. Load-use and jump are ignored because ID holds a wrong-path instruction.
  2. Load-use: IDEX__mem__read=1, IDEX__Rt!=0, and either (IDEX__Rt==IFID__Rs with IFID__use__rs=1) or (IDEX__Rt==IFID__Rt with IFID__use__rt=1). Then pc__load=0, IFID__Ld=0, IDEX__flush=1, IDEX__Ld=1, EXMEM__Ld=1, hazard=1. A pending ID__jump waits and is re-evaluated next cycle.
  3. ID__jump=1: IFID__flush=1, all Ld=1.
  4. Otherwise all Ld=1 and all flushes=0.
- Register 0 never causes a load-use stall.
- stall__cnt increments by 1 at each edge ending a RUN or MEM_WAIT cycle with pc__load=0. It saturates at all-ones and never wraps. It is frozen in INIT and ERR.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum: INIT, RUN, MEM_WAIT, ERR
  - REG_ZERO = 5'd0
  - the control-vector typedef {pc__load, IFID__Ld, IFID__flush, IDEX__Ld, IDEX__flush, EXMEM__Ld, MEMWB__flush}
  - constants CTL_NORMAL, CTL_FREEZE, CTL_INIT and CTL_HALT
- Sub-module lduse_det: purely combinational load-use compare, producing a 1-bit output. Instantiated once.

Test Plan:
- Reset then release with RESET_HOLD=2 -> 2 cycles of all Ld=0 and flushes=1, then RUN with all Ld=1; stall__cnt=0.
- IDEX__mem__read=1, IDEX__Rt=8, IFID__Rs=8, use__rs=1 -> hazard=1, pc__load=0, IFID__Ld=0, IDEX__flush=1 for one cycle; stall__cnt=1. Same stimulus with IDEX__Rt=0 -> no stall.
- Load-use stimulus plus EX__branch__taken=1 in the same cycle -> branch wins: pc__load=1, IFID__flush=IDEX__flush=1, hazard=0.
- dmem__req=1, dmem__ready=0 for 3 cycles, then ready=1 -> 3 freeze cycles with MEMWB__flush=1, then normal advance; back in RUN; stall__cnt=3.
- MEM_TIMEOUT=4, dmem__req=1 with ready stuck at 0 -> after the 4th wait cycle, state=ERR, mem__timeout=1, all Ld=0. Stays in ERR until rst=0.
- Assert rst=0 asynchronously mid-MEM_WAIT -> outputs switch to INIT values before the next clock edge, stall__cnt=0, mem__timeout=0.
